// File: rtl/updown_game_ctrl_pkg.sv
// Shared types and constants for the up/down guessing game controller.
package updown_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [1:0] RES_WIN  = 2'b00;
    localparam logic [1:0] RES_UP   = 2'b01;
    localparam logic [1:0] RES_DOWN = 2'b10;
    localparam logic [1:0] RES_NONE = 2'b11;

    localparam logic [6:0] LOSE_STATUS = 7'h7F;

    // Folds a preset or LFSR value into the legal target range 0..max_val.
    // A preset above the range is clamped. An LFSR value above the range is
    // wrapped down by (max_val + 1). Because max_val is at most 126, that
    // sum still fits in 7 bits and the subtraction cannot underflow.
    function automatic logic [6:0] pick_target(input logic       use_preset,
                                               input logic [6:0] preset,
                                               input logic [6:0] lfsr,
                                               input logic [6:0] max_val);
        logic [6:0] t;
        if (use_preset) begin
            t = (preset > max_val) ? max_val : preset;
        end else begin
            t = (lfsr > max_val) ? (lfsr - (max_val + 7'd1)) : lfsr;
        end
        return t;
    endfunction

endpackage

// File: rtl/updown_game_ctrl_if.sv
// Player/display-side signal bundle of the guessing game controller.
interface updown_game_ctrl_if;

    logic       start;
    logic       preset_en;
    logic [6:0] preset_val;
    logic       guess_valid;
    logic [6:0] guess;

    logic       ready;
    logic       guess_err;
    logic [1:0] result;
    logic [6:0] game_status;
    logic       game_over;
    logic [3:0] tries_used;

    modport master (
        output start, preset_en, preset_val, guess_valid, guess,
        input  ready, guess_err, result, game_status, game_over, tries_used
    );

    modport slave (
        input  start, preset_en, preset_val, guess_valid, guess,
        output ready, guess_err, result, game_status, game_over, tries_used
    );

endinterface

// File: rtl/updown_game_ctrl_lfsr.sv
// 7-bit Fibonacci LFSR (x^7 + x^6 + 1) used as the free-running target source.
module updown_lfsr #(
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] value
);

    // Shift left every cycle, feeding back the XOR of the two top taps.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else begin
            value <= {value[5:0], value[6] ^ value[5]};
        end
    end

endmodule

// File: rtl/updown_game_ctrl.sv
// Up/down number-guessing game sequencer: target pick, guess compare,
// try counting and the registered verdict seen by the display decoder.
module updown_game_ctrl
    import updown_pkg::*;
#(
    parameter int         MAX_VAL   = 99,
    parameter int         MAX_TRIES = 7,
    parameter logic [6:0] LFSR_SEED = 7'h5A
) (
    input  logic               clk,
    input  logic               reset,
    updown_game_ctrl_if.slave  bus
);

    localparam logic [6:0] MAX_VAL_7   = 7'(MAX_VAL);
    localparam logic [3:0] MAX_TRIES_4 = 4'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [6:0] target_q, target_d;
    logic [6:0] guess_q, guess_d;
    logic [3:0] tries_q, tries_d;
    logic [1:0] result_q, result_d;
    logic [6:0] status_q, status_d;
    logic       over_q, over_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic [6:0] lfsr_value;

    updown_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    // State and every output-facing register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            guess_q  <= '0;
            tries_q  <= '0;
            result_q <= RES_NONE;
            status_q <= '0;
            over_q   <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            guess_q  <= guess_d;
            tries_q  <= tries_d;
            result_q <= result_d;
            status_q <= status_d;
            over_q   <= over_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-output logic. CHECK is a single settling cycle in
    // which start is deliberately not looked at. Every other state honours
    // start, which also takes priority over a guess arriving in the same cycle.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        guess_d  = guess_q;
        tries_d  = tries_q;
        result_d = result_q;
        status_d = status_q;
        over_d   = over_q;
        err_d    = 1'b0;

        case (state_q)
            S_CHECK: begin
                tries_d = tries_q + 4'd1;
                if (guess_q == target_q) begin
                    result_d = RES_WIN;
                    status_d = {3'b000, tries_d};
                    over_d   = 1'b1;
                    state_d  = S_WIN;
                end else begin
                    result_d = (guess_q < target_q) ? RES_UP : RES_DOWN;
                    if (tries_d == MAX_TRIES_4) begin
                        status_d = LOSE_STATUS;
                        over_d   = 1'b1;
                        state_d  = S_LOSE;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    target_d = pick_target(bus.preset_en, bus.preset_val,
                                           lfsr_value, MAX_VAL_7);
                    tries_d  = '0;
                    result_d = RES_NONE;
                    status_d = '0;
                    over_d   = 1'b0;
                    state_d  = S_PLAY;
                end else if ((state_q == S_PLAY) && bus.guess_valid) begin
                    if (bus.guess > MAX_VAL_7) begin
                        err_d = 1'b1;
                    end else begin
                        guess_d = bus.guess;
                        state_d = S_CHECK;
                    end
                end
            end
        endcase

        ready_d = (state_d == S_PLAY);
    end

    assign bus.ready       = ready_q;
    assign bus.guess_err   = err_q;
    assign bus.result      = result_q;
    assign bus.game_status = status_q;
    assign bus.game_over   = over_q;
    assign bus.tries_used  = tries_q;

endmodule

// File: tb/tb_updown_game_ctrl.sv
// Self-checking bench for updown_game_ctrl: a game-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_updown_game_ctrl;

    localparam int         MAX_VAL   = 99;
    localparam int         MAX_TRIES = 7;
    localparam logic [6:0] LFSR_SEED = 7'h5A;

    logic clk;
    logic reset;

    updown_game_ctrl_if bus();

    updown_game_ctrl #(
        .MAX_VAL   (MAX_VAL),
        .MAX_TRIES (MAX_TRIES),
        .LFSR_SEED (LFSR_SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, in game terms rather than controller states.
    bit cmp_en = 1'b0;
    int m_lfsr, m_target, m_guess, m_tries, m_res, m_status;
    bit m_active, m_pending, m_over, m_err;

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input int exp);
        n_checks++;
        if (act !== 8'(exp)) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: a guess taken in one cycle produces its verdict on the
    // following edge, during which start is not honoured.
    always @(posedge clk) begin
        if (reset) begin
            m_active  = 1'b0;
            m_pending = 1'b0;
            m_over    = 1'b0;
            m_err     = 1'b0;
            m_res     = 3;
            m_status  = 0;
            m_tries   = 0;
            m_lfsr    = int'(LFSR_SEED);
            cmp_en    = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_pending) begin
                m_pending = 1'b0;
                m_tries   = m_tries + 1;
                if (m_guess == m_target) begin
                    m_res    = 0;
                    m_status = m_tries;
                    m_over   = 1'b1;
                end else begin
                    m_res = (m_guess < m_target) ? 1 : 2;
                    if (m_tries == MAX_TRIES) begin
                        m_status = 127;
                        m_over   = 1'b1;
                    end else begin
                        m_active = 1'b1;
                    end
                end
            end else if (bus.start) begin
                if (bus.preset_en)
                    m_target = (int'(bus.preset_val) > MAX_VAL) ? MAX_VAL : int'(bus.preset_val);
                else
                    m_target = (m_lfsr > MAX_VAL) ? m_lfsr - (MAX_VAL + 1) : m_lfsr;
                m_tries  = 0;
                m_res    = 3;
                m_status = 0;
                m_over   = 1'b0;
                m_active = 1'b1;
            end else if (m_active && bus.guess_valid) begin
                if (int'(bus.guess) > MAX_VAL) begin
                    m_err = 1'b1;
                end else begin
                    m_guess   = int'(bus.guess);
                    m_pending = 1'b1;
                    m_active  = 1'b0;
                end
            end
            m_lfsr = ((m_lfsr << 1) & 127) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_ready",       8'(bus.ready),       int'(m_active));
            checkOutput("cyc_guess_err",   8'(bus.guess_err),   int'(m_err));
            checkOutput("cyc_result",      8'(bus.result),      m_res);
            checkOutput("cyc_game_status", 8'(bus.game_status), m_status);
            checkOutput("cyc_game_over",   8'(bus.game_over),   int'(m_over));
            checkOutput("cyc_tries_used",  8'(bus.tries_used),  m_tries);
        end
    end

    // Drives one cycle of inputs from a negedge and drops the pulses at the next.
    task automatic applyStimulus(input logic st, input logic pe, input logic [6:0] pv,
                                 input logic gv, input logic [6:0] g);
        bus.start       = st;
        bus.preset_en   = pe;
        bus.preset_val  = pv;
        bus.guess_valid = gv;
        bus.guess       = g;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.guess_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_game(input logic pe, input logic [6:0] pv);
        applyStimulus(1'b1, pe, pv, 1'b0, 7'd0);
    endtask

    task automatic send_guess(input logic [6:0] g);
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, g);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.preset_en   = 1'b0;
        bus.preset_val  = 7'd0;
        bus.guess_valid = 1'b0;
        bus.guess       = 7'd0;

        // Reset and idle behaviour.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick(1);
        checkOutput("rst_result",     8'(bus.result),      3);
        checkOutput("rst_game_over",  8'(bus.game_over),   0);
        checkOutput("rst_ready",      8'(bus.ready),       0);
        checkOutput("rst_tries",      8'(bus.tries_used),  0);
        checkOutput("rst_status",     8'(bus.game_status), 0);
        send_guess(7'd10);
        checkOutput("idle_guess_err", 8'(bus.guess_err),   0);
        checkOutput("idle_guess_res", 8'(bus.result),      3);
        checkOutput("idle_guess_rdy", 8'(bus.ready),       0);

        // Binary-search win against preset 42.
        start_game(1'b1, 7'd42);
        checkOutput("bs_start_ready", 8'(bus.ready),       1);
        checkOutput("bs_start_res",   8'(bus.result),      3);
        send_guess(7'd50);
        checkOutput("bs_check_ready", 8'(bus.ready),       0);
        checkOutput("bs_check_res",   8'(bus.result),      3);
        tick(1);
        checkOutput("bs_g50_res",     8'(bus.result),      2);
        checkOutput("bs_g50_tries",   8'(bus.tries_used),  1);
        send_guess(7'd25);
        tick(1);
        checkOutput("bs_g25_res",     8'(bus.result),      1);
        send_guess(7'd42);
        tick(1);
        checkOutput("bs_g42_res",     8'(bus.result),      0);
        checkOutput("bs_g42_over",    8'(bus.game_over),   1);
        checkOutput("bs_g42_status",  8'(bus.game_status), 3);
        checkOutput("bs_g42_ready",   8'(bus.ready),       0);

        // Out-of-range guess, then a full loss against target 0.
        start_game(1'b1, 7'd0);
        send_guess(7'd100);
        checkOutput("oor_err",        8'(bus.guess_err),   1);
        checkOutput("oor_ready",      8'(bus.ready),       1);
        checkOutput("oor_tries",      8'(bus.tries_used),  0);
        tick(1);
        checkOutput("oor_err_drop",   8'(bus.guess_err),   0);
        for (int i = 0; i < MAX_TRIES; i++) begin
            send_guess(7'd5);
            tick(1);
            checkOutput("loss_res",   8'(bus.result),      2);
            checkOutput("loss_tries", 8'(bus.tries_used),  i + 1);
        end
        checkOutput("loss_over",      8'(bus.game_over),   1);
        checkOutput("loss_status",    8'(bus.game_status), 127);
        send_guess(7'd5);
        tick(1);
        checkOutput("loss_8th_tries", 8'(bus.tries_used),  7);
        checkOutput("loss_8th_stat",  8'(bus.game_status), 127);

        // start together with a guess in PLAY: start wins.
        start_game(1'b1, 7'd30);
        send_guess(7'd10);
        tick(1);
        checkOutput("sim_pre_res",    8'(bus.result),      1);
        applyStimulus(1'b1, 1'b1, 7'd30, 1'b1, 7'd10);
        checkOutput("sim_tries",      8'(bus.tries_used),  0);
        checkOutput("sim_res",        8'(bus.result),      3);
        tick(1);
        checkOutput("sim_ready_hold", 8'(bus.ready),       1);

        // start during CHECK is ignored; target stays 30.
        send_guess(7'd40);
        start_game(1'b1, 7'd77);
        checkOutput("chk_start_res",  8'(bus.result),      2);
        checkOutput("chk_start_try",  8'(bus.tries_used),  1);
        send_guess(7'd30);
        tick(1);
        checkOutput("chk_start_win",  8'(bus.result),      0);
        checkOutput("chk_start_stat", 8'(bus.game_status), 2);

        // reset during CHECK aborts the game.
        start_game(1'b1, 7'd50);
        send_guess(7'd10);
        reset = 1'b1;
        tick(1);
        checkOutput("rchk_res",       8'(bus.result),      3);
        checkOutput("rchk_tries",     8'(bus.tries_used),  0);
        checkOutput("rchk_ready",     8'(bus.ready),       0);
        reset = 1'b0;

        // First start after reset takes the seed 0x5A = 90 as target.
        start_game(1'b0, 7'd0);
        send_guess(7'd90);
        tick(1);
        checkOutput("seed_win",       8'(bus.result),      0);
        checkOutput("seed_status",    8'(bus.game_status), 1);

        // Wait for the LFSR to hold 120, which wraps down to target 20.
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_lfsr == 120) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL lfsr_reach_120: got no match, expected value 120 within 300 cycles");
        end
        start_game(1'b0, 7'd0);
        send_guess(7'd20);
        tick(1);
        checkOutput("lfsr120_win",    8'(bus.result),      0);

        // Preset 127 clamps to 99.
        start_game(1'b1, 7'd127);
        send_guess(7'd98);
        tick(1);
        checkOutput("clamp_g98_res",  8'(bus.result),      1);
        send_guess(7'd99);
        tick(1);
        checkOutput("clamp_g99_res",  8'(bus.result),      0);
        checkOutput("clamp_status",   8'(bus.game_status), 2);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
